// File: rtl/peak_serializer.sv
// Frame FIFO + framed 32-bit word stream for per-band peak lists (A5 header, then peak words).
// Optional macro PEAK_SKIP_ZERO_EN: zero-amplitude peaks are left out of the stream and of N.
module peak_serializer #(
  parameter int PEAKS      = 6,
  parameter int AMPL_WIDTH = 16,
  parameter int FREQ_WIDTH = 9,
  parameter int TIME_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        frame_valid,
  input  logic [PEAKS*AMPL_WIDTH-1:0] amplitudes_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
  input  logic [TIME_WIDTH-1:0]       counter_in,
  output logic [31:0]                 word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        word_last,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [7:0]                  drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = (PEAKS > 1) ? $clog2(PEAKS) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, PEAK} state_t;

  logic [PEAKS*AMPL_WIDTH-1:0] amp_mem  [DEPTH];
  logic [PEAKS*FREQ_WIDTH-1:0] freq_mem [DEPTH];
  logic [TIME_WIDTH-1:0]       time_mem [DEPTH];

  logic                        fv_q_reg;
  logic [PW-1:0]               wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]               level_reg;
  logic [7:0]                  drop_reg;
  state_t                      state_reg;
  logic [IW-1:0]               idx_reg;
  logic [PEAKS*AMPL_WIDTH-1:0] out_amp_reg;
  logic [PEAKS*FREQ_WIDTH-1:0] out_freq_reg;

  logic                        capture, handshake, pop, push, full;
  logic [PEAKS*AMPL_WIDTH-1:0] head_amps;
  logic [PEAKS-1:0]            head_mask, cur_mask, later_any;
  logic [7:0]                  head_count;
  logic [IW-1:0]               first_idx, next_idx;
  logic [31:0]                 header_word, first_word, next_word;

  assign capture    = frame_valid & ~fv_q_reg;
  assign handshake  = word_valid & word_ready;
  assign pop        = handshake & word_last;
  assign full       = (level_reg == LW'(DEPTH));
  assign push       = capture & (~full | pop);
  assign head_amps  = amp_mem[rd_ptr_reg];
  assign fifo_level = level_reg;
  assign drop_count = drop_reg;

  function automatic logic [31:0] make_peak(input logic [AMPL_WIDTH-1:0] a,
                                            input logic [FREQ_WIDTH-1:0] f);
    make_peak = '0;
    make_peak[AMPL_WIDTH-1:0] = a;
    make_peak[AMPL_WIDTH +: FREQ_WIDTH] = f;
  endfunction

  // cur_mask marks peaks of the frame in the output stage that will be emitted;
  // later_any[i] says whether any emitted peak follows index i.
  generate
    for (genvar gi = 0; gi < PEAKS; gi++) begin : g_mask
`ifdef PEAK_SKIP_ZERO_EN
      assign head_mask[gi] = |head_amps[gi*AMPL_WIDTH +: AMPL_WIDTH];
      assign cur_mask[gi]  = |out_amp_reg[gi*AMPL_WIDTH +: AMPL_WIDTH];
`else
      assign head_mask[gi] = 1'b1;
      assign cur_mask[gi]  = 1'b1;
`endif
      if (gi == PEAKS-1) begin : g_top
        assign later_any[gi] = 1'b0;
      end else begin : g_mid
        assign later_any[gi] = |cur_mask[PEAKS-1:gi+1];
      end
    end
  endgenerate

  always_comb begin
    head_count = '0;
    first_idx  = '0;
    next_idx   = idx_reg;
    for (int k = 0; k < PEAKS; k++)
      head_count = head_count + 8'(head_mask[k]);
    for (int k = PEAKS-1; k >= 0; k--) begin
      if (cur_mask[k]) first_idx = IW'(k);
      if (cur_mask[k] && (IW'(k) > idx_reg)) next_idx = IW'(k);
    end
    header_word = 32'(time_mem[rd_ptr_reg]);
    header_word[31:16] = {8'hA5, head_count};
    first_word = make_peak(out_amp_reg[first_idx*AMPL_WIDTH +: AMPL_WIDTH],
                           out_freq_reg[first_idx*FREQ_WIDTH +: FREQ_WIDTH]);
    next_word  = make_peak(out_amp_reg[next_idx*AMPL_WIDTH +: AMPL_WIDTH],
                           out_freq_reg[next_idx*FREQ_WIDTH +: FREQ_WIDTH]);
  end

  // Storage has no reset; the pointers alone define what is buffered.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      amp_mem[wr_ptr_reg]  <= amplitudes_in;
      freq_mem[wr_ptr_reg] <= freqs_in;
      time_mem[wr_ptr_reg] <= counter_in;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fv_q_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      drop_reg   <= '0;
    end else begin
      fv_q_reg <= frame_valid;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      level_reg <= level_reg + 1'b1;
      else if (pop && !push) level_reg <= level_reg - 1'b1;
      if (capture && full && !pop && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      word_valid <= 1'b0;
      word_out   <= '0;
      word_last  <= 1'b0;
      idx_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (level_reg != '0) begin
            state_reg    <= HEADER;
            out_amp_reg  <= head_amps;
            out_freq_reg <= freq_mem[rd_ptr_reg];
            word_out     <= header_word;
            word_valid   <= 1'b1;
            word_last    <= (head_count == 8'd0);
          end
        end
        HEADER: begin
          if (handshake) begin
            if (word_last) begin
              state_reg  <= IDLE;
              word_valid <= 1'b0;
            end else begin
              state_reg <= PEAK;
              idx_reg   <= first_idx;
              word_out  <= first_word;
              word_last <= ~later_any[first_idx];
            end
          end
        end
        PEAK: begin
          if (handshake) begin
            if (word_last) begin
              state_reg  <= IDLE;
              word_valid <= 1'b0;
            end else begin
              idx_reg   <= next_idx;
              word_out  <= next_word;
              word_last <= ~later_any[next_idx];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/peak_serializer.md
# peak_serializer

Consumer side of the peak-detector output. Captures each frame's per-band peak list (amplitude, frequency bin, time counter) into a small frame FIFO. Drains that FIFO as a framed 32-bit word stream with a valid/ready handshake, toward the fingerprint/host interface. Decouples the irregular FFT frame rate from a back-pressured downstream reader.

## Interface
- PEAKS, 6, peaks (bands) per frame
- AMPL_WIDTH, 16, signed amplitude width; AMPL_WIDTH+FREQ_WIDTH ≤ 32
- FREQ_WIDTH, 9, unsigned frequency-bin width
- TIME_WIDTH, 16, time-counter width; ≤ 16
- DEPTH, 4, frame FIFO depth in frames; power of two, ≥ 2
- CLOCK_50  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- frame_valid  in  1  level from producer; a new frame is indicated by its rising edge
- amplitudes_in  in  PEAKS*AMPL_WIDTH  packed; peak k at [k*AMPL_WIDTH +: AMPL_WIDTH]
- freqs_in  in  PEAKS*FREQ_WIDTH  packed; peak k at [k*FREQ_WIDTH +: FREQ_WIDTH]
- counter_in  in  TIME_WIDTH  frame time stamp
- word_out  out  32  stream data
- word_valid  out  1  word_out is valid
- word_ready  in  1  downstream accepts word this cycle
- word_last  out  1  final word of the current frame
- fifo_level  out  $clog2(DEPTH)+1  frames currently buffered
- drop_count  out  8  frames dropped because the FIFO was full; saturates at 255

## Operation
- **Edge detect:**
  - frame_valid is registered as fv_q.
  - A capture occurs in any cycle with frame_valid=1 and fv_q=0.
  - The inputs are sampled at that same edge.
- **Capture:**
  - On capture, the full frame (PEAKS amplitudes, PEAKS freqs, counter_in) is written to the FIFO tail.
  - If the FIFO is full and no pop occurs in the same cycle, the frame is discarded and drop_count increments (saturating).
  - Capture and pop in the same cycle are both performed, so a full FIFO still accepts the frame; fifo_level is unchanged.
- **Frame format:** 1 header word followed by N peak words.
  - Header: [31:24]=8'hA5, [23:16]=N, [15:0]=counter zero-extended.
  - Peak word: [AMPL_WIDTH-1:0]=amplitude (two's complement, unmodified); [AMPL_WIDTH+FREQ_WIDTH-1:AMPL_WIDTH]=freq; remaining upper bits 0.
  - Peaks are emitted in ascending index k. N=PEAKS unless PEAK_SKIP_ZERO_EN is defined.
- **FSM states:** IDLE, HEADER, PEAK.
  - IDLE: word_valid=0. If fifo_level≠0, go to HEADER and load the head frame into the output stage.
  - HEADER: present the header. On word_valid&&word_ready, go to PEAK with idx=first emitted peak. If N=0, the header carries word_last=1; the handshake pops the FIFO and the FSM goes to IDLE.
  - PEAK: present peak idx. On handshake, advance to the next emitted idx. On the last emitted peak, word_last=1; the handshake pops the FIFO and the FSM goes to IDLE.
- **Handshake:**
  - Once word_valid=1, word_out and word_last hold stable until a handshake occurs.
  - word_valid never drops without a handshake, except on reset.
- FIFO pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.

## Timing
- **Reset values:** word_valid=0, word_out=0, word_last=0, fifo_level=0, drop_count=0, FSM=IDLE, fv_q=0.
- **Reset mid-frame:** the FIFO is flushed and the partial frame is abandoned. Outputs take their reset values at the edge where reset=1.
- **Capture latency:** capture at edge E0 gives fifo_level+1 after E0. The FSM enters HEADER at E1, so word_valid=1 after E1. First header is therefore 2 edges after the sampled rising edge.
- **Throughput:**
  - With word_ready held at 1, one word per cycle within a frame.
  - One IDLE bubble cycle between frames, so a frame costs N+2 cycles.
- **Level timing:** fifo_level decrements on the cycle of the last-word handshake.
- A frame_valid level held high produces exactly one capture. It must return low for ≥1 cycle before the next frame.

## Configuration
- **PEAK_SKIP_ZERO_EN defined:**
  - Peaks with amplitude == 0 are not emitted.
  - N in the header equals the count of nonzero amplitudes; the count is computed combinationally from the head entry when entering HEADER.
  - The all-zero case yields a header-only frame with word_last=1.
- **Undefined:** all PEAKS peaks are always emitted and N=PEAKS.

## Test plan
- **Single frame:**
  - Stimulus: amps {10,-3,0,7,200,1}, freqs {5,40,0,90,150,300}, counter 0x0012, ready=1.
  - Response: words 0xA5060012, 0x0005000A, 0x0028FFFD, 0x00000000, 0x005A0007, 0x009600C8, 0x012C0001. word_last only on the last word; header valid 2 edges after the capture edge.
- **Back-pressure:** same frame with word_ready toggling 1,0,0,1,…
  - Response: word_out/word_last stable while ready=0, and the identical 7-word sequence is produced.
- **Overflow:** ready=0, 6 captures with DEPTH=4.
  - Response: fifo_level=4, drop_count=2.
  - Then ready=1: 4 frames are drained in capture order, counters 0..3.
- **Full plus simultaneous pop:** FIFO full, capture on the same cycle as a last-word handshake.
  - Response: frame accepted, fifo_level stays 4, drop_count unchanged.
- **Reset mid-frame:** reset after the header plus 2 peak words.
  - Response: next edge gives word_valid=0 and fifo_level=0. A new capture afterwards starts with a header.
- **PEAK_SKIP_ZERO_EN:**
  - amps {0,0,5,0,0,0} gives 0xA501cccc followed by the single peak word with word_last=1.
  - All-zero amps give a header 0xA500cccc with word_last=1.
